// File: rtl/input_conditioner.sv
// Front-end conditioning for 5 buttons and 2 switches: 2-flop synchronizers, counter debounce,
// registered press strobes and per-channel timed auto-repeat on REP_MASK channels.
module input_conditioner #(
    parameter int unsigned DB_CYCLES  = 100000,
    parameter int unsigned REP_DELAY  = 5000000,
    parameter int unsigned REP_PERIOD = 1000000,
    parameter logic [4:0]  REP_MASK   = 5'b11000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    input  logic [1:0] sw_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic [1:0] sw_level
);

    localparam int unsigned NBTN    = 5;
    localparam int unsigned NCH     = 7;
    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    // Counters compare against N-1 so the change lands on the edge where the count would reach N.
    localparam logic [DB_W-1:0]  DB_LAST         = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_e;

    logic [NCH-1:0]  raw_all;
    logic [NCH-1:0]  sync1_q;
    logic [NCH-1:0]  sync2_q;
    logic [NCH-1:0]  stable_q;
    logic [NCH-1:0]  stable_d;
    logic [DB_W-1:0] db_cnt_q [NCH];
    logic [DB_W-1:0] db_cnt_d [NCH];
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] fall;
    logic [NBTN-1:0] rep_fire;
    logic [NBTN-1:0] pulse_q;
    logic [NBTN-1:0] pulse_d;

    assign raw_all = {sw_raw, btn_raw};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_all;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // NOTE: the counter array is small and control-relevant, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign rise = stable_d[NBTN-1:0] & ~stable_q[NBTN-1:0];
    assign fall = ~stable_d[NBTN-1:0] & stable_q[NBTN-1:0];

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        if (REP_MASK[g]) begin : g_rep
            rep_state_e       state_q;
            rep_state_e       state_d;
            logic [REP_W-1:0] cnt_q;
            logic [REP_W-1:0] cnt_d;
            logic             fire;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                fire    = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rise[g]) begin
                            state_d = ST_DELAY;
                            cnt_d   = '0;
                        end
                    end
                    ST_DELAY: begin
                        // A release wins over a due repeat pulse on the same edge.
                        if (fall[g]) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == REP_DELAY_LAST) begin
                            fire    = 1'b1;
                            state_d = ST_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + REP_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (fall[g]) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == REP_PERIOD_LAST) begin
                            fire  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + REP_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign rep_fire[g] = fire;
        end else begin : g_norep
            assign rep_fire[g] = 1'b0;
        end
    end

    // Registered so the strobe lines up with the cycle the debounced level first reads high.
    assign pulse_d = rise | rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign btn_level = stable_q[NBTN-1:0];
    assign sw_level  = stable_q[NCH-1:NBTN];
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: hand-derived vector table, corner sequences,
// and a randomized run compared every cycle against a window/arithmetic reference model.
module tb_input_conditioner;

    localparam int          DB    = 4;
    localparam int          RD    = 20;
    localparam int          RP    = 8;
    localparam logic [4:0]  RMASK = 5'b11000;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [1:0] sw_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [1:0] sw_level;

    always #5 clk = ~clk;

    input_conditioner #(
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP),
        .REP_MASK  (RMASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .sw_level (sw_level)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw delayed two samples, level flips once the last DB samples all disagree,
    // repeat pulses at press + RD + n*RP while the level stays high.
    logic [6:0]    pipe1   = '0;
    logic [6:0]    pipe2   = '0;
    logic [6:0]    m_level = '0;
    logic [4:0]    m_pulse = '0;
    logic [DB-1:0] hist [7];
    int            press [5];
    int            cyc = 0;

    typedef struct {
        logic       r;
        logic [4:0] b;
        logic [1:0] s;
        int         n;
        logic [4:0] lvl;
        logic [4:0] pls;
        logic [1:0] swl;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [4:0] b, input logic [1:0] s);
        logic [6:0] prev;
        int         d;
        prev    = m_level;
        cyc++;
        m_pulse = '0;
        if (r) begin
            pipe1   = '0;
            pipe2   = '0;
            m_level = '0;
            for (int c = 0; c < 7; c++) hist[c] = '0;
            for (int i = 0; i < 5; i++) press[i] = -1;
        end else begin
            for (int c = 0; c < 7; c++) begin
                hist[c] = {hist[c][DB-2:0], pipe2[c]};
                if (prev[c] ? (hist[c] == '0) : (&hist[c])) m_level[c] = ~prev[c];
            end
            pipe2 = pipe1;
            pipe1 = {s, b};
            for (int i = 0; i < 5; i++) begin
                if (!prev[i] && m_level[i]) begin
                    m_pulse[i] = 1'b1;
                    press[i]   = cyc;
                end else if (prev[i] && m_level[i] && RMASK[i] && press[i] >= 0) begin
                    d = cyc - press[i];
                    if (d >= RD && ((d - RD) % RP) == 0) m_pulse[i] = 1'b1;
                end
            end
        end
    endtask

    // Drive inputs, take one rising edge, update the model, compare 1 time unit later.
    task automatic tick(input logic r, input logic [4:0] b, input logic [1:0] s);
        rst     = r;
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk);
        model_edge(r, b, s);
        #1;
        check("model", {btn_level, btn_pulse, sw_level}, {m_level[4:0], m_pulse, m_level[6:5]});
    endtask

    initial begin
        logic [4:0] rb;
        logic [1:0] rs;
        logic       rr;

        rst     = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        for (int c = 0; c < 7; c++) hist[c] = '0;
        for (int i = 0; i < 5; i++) press[i] = -1;

        //              r     btn      sw     n   lvl      pls      swl
        tbl.push_back('{1'b1, 5'h1F, 2'b11,  2, 5'h00, 5'h00, 2'b00}); // reset forces zeros
        tbl.push_back('{1'b0, 5'h00, 2'b00,  8, 5'h00, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h01, 2'b00,  5, 5'h00, 5'h00, 2'b00}); // start: E0..E0+4
        tbl.push_back('{1'b0, 5'h01, 2'b00,  1, 5'h01, 5'h01, 2'b00}); // E0+5 level + pulse
        tbl.push_back('{1'b0, 5'h01, 2'b00,  1, 5'h01, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h01, 2'b00, 30, 5'h01, 5'h00, 2'b00}); // no repeat on start
        tbl.push_back('{1'b0, 5'h00, 2'b00,  5, 5'h01, 5'h00, 2'b00}); // falling latency
        tbl.push_back('{1'b0, 5'h00, 2'b00,  1, 5'h00, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h00, 2'b10,  6, 5'h00, 5'h00, 2'b10}); // mode_sw
        tbl.push_back('{1'b0, 5'h00, 2'b00,  6, 5'h00, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h08, 2'b00,  6, 5'h08, 5'h08, 2'b00}); // inc_min press P
        tbl.push_back('{1'b0, 5'h08, 2'b00, 19, 5'h08, 5'h00, 2'b00}); // P+19
        tbl.push_back('{1'b0, 5'h08, 2'b00,  1, 5'h08, 5'h08, 2'b00}); // P+20 first repeat
        tbl.push_back('{1'b0, 5'h08, 2'b00,  7, 5'h08, 5'h00, 2'b00}); // P+27
        tbl.push_back('{1'b0, 5'h08, 2'b00,  1, 5'h08, 5'h08, 2'b00}); // P+28
        tbl.push_back('{1'b0, 5'h00, 2'b00,  5, 5'h08, 5'h00, 2'b00}); // release
        tbl.push_back('{1'b0, 5'h00, 2'b00,  1, 5'h00, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h18, 2'b00,  6, 5'h18, 5'h18, 2'b00}); // simultaneous press
        tbl.push_back('{1'b0, 5'h18, 2'b00, 20, 5'h18, 5'h18, 2'b00}); // simultaneous repeat
        tbl.push_back('{1'b0, 5'h00, 2'b00, 10, 5'h00, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h10, 2'b00,  6, 5'h10, 5'h10, 2'b00}); // inc_sec press P
        tbl.push_back('{1'b0, 5'h10, 2'b00,  9, 5'h10, 5'h00, 2'b00}); // P+9
        tbl.push_back('{1'b1, 5'h10, 2'b00,  2, 5'h00, 5'h00, 2'b00}); // reset at P+10
        tbl.push_back('{1'b0, 5'h10, 2'b00,  5, 5'h00, 5'h00, 2'b00}); // release R..R+4
        tbl.push_back('{1'b0, 5'h10, 2'b00,  1, 5'h10, 5'h10, 2'b00}); // R+5 new press
        tbl.push_back('{1'b0, 5'h10, 2'b00, 19, 5'h10, 5'h00, 2'b00});
        tbl.push_back('{1'b0, 5'h10, 2'b00,  1, 5'h10, 5'h10, 2'b00}); // R+25 repeat
        tbl.push_back('{1'b0, 5'h00, 2'b00,  6, 5'h00, 5'h00, 2'b00});

        for (int k = 0; k < tbl.size(); k++) begin
            for (int c = 0; c < tbl[k].n; c++) tick(tbl[k].r, tbl[k].b, tbl[k].s);
            check($sformatf("vec%0d", k), {btn_level, btn_pulse, sw_level},
                  {tbl[k].lvl, tbl[k].pls, tbl[k].swl});
        end

        // stop held for 3 cycles: must never reach level or pulse.
        for (int c = 0; c < 15; c++) begin
            tick(1'b0, (c < 3) ? 5'h02 : 5'h00, 2'b00);
            check("glitch", {10'd0, btn_level[1], btn_pulse[1]}, 12'd0);
        end

        // softrst held exactly DB cycles: accepted at the threshold.
        for (int c = 0; c < 4; c++) tick(1'b0, 5'h04, 2'b00);
        tick(1'b0, 5'h00, 2'b00);
        check("exact_db_pre", {10'd0, btn_level[2], btn_pulse[2]}, 12'd0);
        tick(1'b0, 5'h00, 2'b00);
        check("exact_db", {10'd0, btn_level[2], btn_pulse[2]}, 12'd3);
        for (int c = 0; c < 10; c++) tick(1'b0, 5'h00, 2'b00);
        check("exact_db_fall", {10'd0, btn_level[2], btn_pulse[2]}, 12'd0);

        // Randomized run: slow toggling on repeat channels so holds reach the repeat window.
        rb = '0;
        rs = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, (i >= 3) ? 60 : 15) == 0) rb[i] = ~rb[i];
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 15) == 0) rs[i] = ~rs[i];
            end
            rr = ($urandom_range(0, 599) == 0);
            tick(rr, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
